// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package arm_rf_pkg;
  localparam int REG_W   = 64;
  localparam int RADDR_W = 5;
  localparam int NREGS   = 32;
  localparam logic [RADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [REG_W-1:0]   data;
  } rf_wr_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback requester bundle plus the regfile write port and hazard outputs.
interface rf_write_arbiter_if #(parameter int NREQ = 2);
  import arm_rf_pkg::*;

  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ-1:0][RADDR_W-1:0] req_reg;
  logic [NREQ-1:0][REG_W-1:0]   req_data;
  logic                         RegWrite;
  logic [RADDR_W-1:0]           WriteRegister;
  logic [REG_W-1:0]             WriteData;
  logic [NREGS-1:0]             pending;
  logic                         idle;

  modport master (
    output req_valid, req_reg, req_data,
    input  req_ready, RegWrite, WriteRegister, WriteData, pending, idle
  );
  modport slave (
    input  req_valid, req_reg, req_data,
    output req_ready, RegWrite, WriteRegister, WriteData, pending, idle
  );
endinterface

// File: rtl/rf_write_arbiter_fifo.sv
// Per-requester writeback FIFO; exposes every slot's valid/rd for the hazard scoreboard.
module rf_wb_fifo
  import arm_rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  rf_wr_t                          din_i,
  output logic                            full_o,
  output logic                            empty_o,
  output rf_wr_t                          head_o,
  output logic [DEPTH-1:0]                ent_vld_o,
  output logic [DEPTH-1:0][RADDR_W-1:0]   ent_rd_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]            wr_q, rd_q;
  rf_wr_t [DEPTH-1:0]     mem_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    assign ent_vld_o[k] = {1'b0, AW'(k) - rd_q[AW-1:0]} < (wr_q - rd_q);
    assign ent_rd_o[k]  = mem_q[k].rd;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin drain of NREQ writeback FIFOs into one registered regfile write port,
// with a pending-write bitmap for RAW stall detection in decode.
module rf_write_arbiter
  import arm_rf_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  rf_write_arbiter_if.slave  bus
);
  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                          push, pop, full, empty;
  rf_wr_t [NREQ-1:0]                        din, head;
  logic [NREQ-1:0][DEPTH-1:0]               ent_vld;
  logic [NREQ-1:0][DEPTH-1:0][RADDR_W-1:0]  ent_rd;

  logic [RRW-1:0] rr_q, rr_d, gnt_idx;
  logic [RRW:0]   cand;
  logic           gnt_vld;
  logic           wen_q;
  rf_wr_t         wr_q;
  logic [NREGS-1:0] pend;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    // X31 writes are acknowledged but dropped at the door.
    assign push[g] = bus.req_valid[g] && !full[g] && (bus.req_reg[g] != ZERO_REG);
    assign pop[g]  = gnt_vld && (gnt_idx == RRW'(g));
    assign din[g]  = {bus.req_reg[g], bus.req_data[g]};
    assign bus.req_ready[g] = !full[g];

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (push[g]),
      .pop_i     (pop[g]),
      .din_i     (din[g]),
      .full_o    (full[g]),
      .empty_o   (empty[g]),
      .head_o    (head[g]),
      .ent_vld_o (ent_vld[g]),
      .ent_rd_o  (ent_rd[g])
    );
  end

  // Scan offsets high to low so the closest non-empty FIFO at/after rr_q is the last assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_q} + (RRW+1)'(i);
      if (cand >= (RRW+1)'(NREQ)) cand = cand - (RRW+1)'(NREQ);
      if (!empty[cand[RRW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[RRW-1:0];
      end
    end
    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == RRW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q  <= '0;
      wen_q <= 1'b0;
      wr_q  <= '0;
    end else begin
      rr_q  <= rr_d;
      wen_q <= gnt_vld;
      if (gnt_vld) wr_q <= head[gnt_idx];
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < DEPTH; k++)
        if (ent_vld[i][k]) pend[ent_rd[i][k]] = 1'b1;
    if (wen_q) pend[wr_q.rd] = 1'b1;
    pend[ZERO_REG] = 1'b0;
  end

  assign bus.RegWrite      = wen_q;
  assign bus.WriteRegister = wr_q.rd;
  assign bus.WriteData     = wr_q.data;
  assign bus.pending       = pend;
  assign bus.idle          = (&empty) && !wen_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scenario tasks plus a negedge scoreboard monitor tracking per-requester order and pending.
module tb_rf_write_arbiter;
  import arm_rf_pkg::*;

  localparam int NREQ  = 2;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.NREQ(NREQ)) bus ();
  rf_write_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Requester id rides in WriteData[63:60] so the monitor can route a retired write.
  rf_wr_t      expq [NREQ][$];
  int          cnt  [NREGS];
  logic [31:0] m_exp_p;
  int          m_tot, m_id;
  rf_wr_t      m_e;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) expq[i].delete();
      for (int r = 0; r < NREGS; r++) cnt[r] = 0;
    end else begin
      m_exp_p = '0;
      m_tot   = 0;
      for (int r = 0; r < NREGS; r++) begin
        if (cnt[r] > 0) m_exp_p[r] = 1'b1;
        m_tot += cnt[r];
      end
      checks++;
      if (bus.pending !== m_exp_p) begin
        errors++;
        $display("FAIL pending t=%0t: got %h want %h", $time, bus.pending, m_exp_p);
      end
      checks++;
      if (bus.idle !== (m_tot == 0)) begin
        errors++;
        $display("FAIL idle t=%0t: got %b want %b", $time, bus.idle, (m_tot == 0));
      end
      if (bus.RegWrite === 1'b1) begin
        m_id = int'(bus.WriteData[63:60]);
        checks++;
        if (m_id >= NREQ || expq[m_id].size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected t=%0t: got X%0d %h want no write", $time,
                   bus.WriteRegister, bus.WriteData);
        end else begin
          m_e = expq[m_id].pop_front();
          if ({bus.WriteRegister, bus.WriteData} !== m_e) begin
            errors++;
            $display("FAIL sb_order t=%0t: got X%0d %h want X%0d %h", $time,
                     bus.WriteRegister, bus.WriteData, m_e.rd, m_e.data);
          end
        end
        if (cnt[bus.WriteRegister] > 0) cnt[bus.WriteRegister]--;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i] && bus.req_reg[i] != ZERO_REG) begin
          expq[i].push_back({bus.req_reg[i], bus.req_data[i]});
          cnt[bus.req_reg[i]]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [4:0] r, input logic [63:0] d);
    bus.req_valid[i] = v;
    bus.req_reg[i]   = r;
    bus.req_data[i]  = d;
  endtask

  task automatic quiet();
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_wr(input string name, input logic [4:0] r, input logic [63:0] d);
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== r || bus.WriteData !== d) begin
      errors++;
      $display("FAIL %s: got we=%b X%0d %h want we=1 X%0d %h", name, bus.RegWrite,
               bus.WriteRegister, bus.WriteData, r, d);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      drive(0, 1'b1, 5'd3, 64'h0000_0000_0000_0100 + 64'(c));
      drive(1, 1'b1, 5'd4, 64'h1000_0000_0000_0200 + 64'(c));
      tick();
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    quiet();
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.pending !== 32'h0 || bus.idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got we=%b pend=%h idle=%b want we=0 pend=0 idle=1",
               bus.RegWrite, bus.pending, bus.idle);
    end
    checks++;
    if (bus.req_ready !== 2'b11 || bus.WriteRegister !== 5'd0 || bus.WriteData !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b X%0d %h want rdy=11 X0 0",
               bus.req_ready, bus.WriteRegister, bus.WriteData);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    drive(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
    tick();
    quiet();
    checks++;
    if (bus.pending[5] !== 1'b1 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL single_t1: got pend5=%b we=%b want pend5=1 we=0", bus.pending[5], bus.RegWrite);
    end
    tick();
    expect_wr("single_t2", 5'd5, 64'hDEAD_BEEF);
    tick();
    checks++;
    if (bus.pending[5] !== 1'b0 || bus.RegWrite !== 1'b0 || bus.idle !== 1'b1) begin
      errors++;
      $display("FAIL single_t3: got pend5=%b we=%b idle=%b want 0 0 1",
               bus.pending[5], bus.RegWrite, bus.idle);
    end
  endtask

  task automatic test_contention();
    do_reset();
    drive(0, 1'b1, 5'd1, 64'h0000_0000_0000_0AAA);
    drive(1, 1'b1, 5'd2, 64'h1000_0000_0000_0BBB);
    tick();
    quiet();
    tick();
    expect_wr("contend_first", 5'd1, 64'h0000_0000_0000_0AAA);
    tick();
    expect_wr("contend_second", 5'd2, 64'h1000_0000_0000_0BBB);
    // A lone req0 write moves the pointer onto req1.
    drive(0, 1'b1, 5'd3, 64'h0000_0000_0000_0CCC);
    tick();
    quiet();
    tick();
    expect_wr("contend_solo", 5'd3, 64'h0000_0000_0000_0CCC);
    tick();
    drive(0, 1'b1, 5'd6, 64'h0000_0000_0000_0DDD);
    drive(1, 1'b1, 5'd7, 64'h1000_0000_0000_0EEE);
    tick();
    quiet();
    tick();
    expect_wr("contend_rr_first", 5'd7, 64'h1000_0000_0000_0EEE);
    tick();
    expect_wr("contend_rr_second", 5'd6, 64'h0000_0000_0000_0DDD);
    tick();
  endtask

  task automatic test_backpressure();
    int n0, n1, first_block;
    n0 = 0;
    n1 = 0;
    first_block = -1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(0, 1'b1, 5'd10, 64'h0000_0000_0000_5000 + 64'(n0));
      drive(1, 1'b1, 5'd11, 64'h1000_0000_0000_6000 + 64'(n1));
      if (bus.req_ready[0]) n0++;
      else if (first_block < 0) first_block = n0;
      if (bus.req_ready[1]) n1++;
      tick();
    end
    quiet();
    for (int c = 0; c < 3 * DEPTH * NREQ; c++) tick();
    checks++;
    if (first_block < DEPTH) begin
      errors++;
      $display("FAIL backpressure_full: got block after %0d accepts want >= %0d", first_block, DEPTH);
    end
    checks++;
    if (expq[0].size() != 0 || expq[1].size() != 0 || bus.idle !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_drain: got q0=%0d q1=%0d idle=%b want 0 0 1",
               expq[0].size(), expq[1].size(), bus.idle);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(0, 1'b1, ZERO_REG, 64'h1);
    checks++;
    if (bus.req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: got %b want 1", bus.req_ready[0]);
    end
    tick();
    quiet();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.RegWrite !== 1'b0 || bus.pending !== 32'h0 || bus.idle !== 1'b1) begin
        errors++;
        $display("FAIL zero_reg c=%0d: got we=%b pend=%h idle=%b want 0 0 1",
                 c, bus.RegWrite, bus.pending, bus.idle);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int seq;
    int rs;
    seq = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        rs = $urandom_range(0, 7);
        drive(i, 1'($urandom_range(0, 1)), (rs == 7) ? ZERO_REG : 5'(rs),
              {4'(i), 28'h0, 32'(seq)});
        seq++;
      end
      tick();
    end
    quiet();
    for (int c = 0; c < 20; c++) tick();
    checks++;
    if (expq[0].size() != 0 || expq[1].size() != 0 || bus.idle !== 1'b1) begin
      errors++;
      $display("FAIL random_drain: got q0=%0d q1=%0d idle=%b want 0 0 1",
               expq[0].size(), expq[1].size(), bus.idle);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_reg   = '0;
    bus.req_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_single_write();
    test_contention();
    test_backpressure();
    test_zero_reg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
